// File: rtl/key_display_pkg.sv
// Shared constants and types for the key history display.
package key_display_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a}; element 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Which history slot the mux is currently driving.
  typedef enum logic {
    DIG_NEW = 1'b0,
    DIG_OLD = 1'b1
  } digit_sel_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex digit to active-high seven-segment pattern.
module hex_to_sevenseg
  import key_display_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Pure table lookup; polarity is applied by the parent.
  always_comb begin
    o_seg = seg_encode(i_hex);
  end

endmodule

// File: rtl/key_display_mux.sv
// Two-key history (newest/previous) time-multiplexed onto a dual 7-segment display,
// with a one-cycle blanking gap between digit windows.
module key_display_mux
  import key_display_pkg::*;
#(
  parameter int unsigned MUX_DIV        = 12000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [6:0] seg,
  output logic [1:0] anode,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  if (MUX_DIV < 2) begin : g_bad_mux_div
    $fatal(1, "key_display_mux: MUX_DIV must be >= 2");
  end

  localparam int unsigned DivW    = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(MUX_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);

  // XOR masks turn active-high internal values into pin polarity.
  localparam logic [6:0] SegMask = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] AnMask  = {2{AN_ACTIVE_LOW}};

  // History registers
  logic [3:0] r_new_d;
  logic [3:0] r_old_d;
  logic       r_new_vld;
  logic       r_old_vld;

  // Mux sequencing state
  logic [DivW-1:0] r_div_cnt;
  digit_sel_t      r_sel;
  logic            r_dead;

  logic [DivW-1:0] w_div_cnt_nxt;
  digit_sel_t      w_sel_nxt;
  logic            w_dead_nxt;
  logic            w_div_last;

  // Output datapath
  logic [6:0] r_seg;
  logic [1:0] r_anode;
  logic [3:0] w_digit;
  logic       w_digit_vld;
  logic [6:0] w_enc;
  logic [6:0] w_seg_act;
  logic [1:0] w_an_act;

  // Shift the key history on every strobe, including repeats and back-to-back strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_new_d   <= 4'h0;
      r_old_d   <= 4'h0;
      r_new_vld <= 1'b0;
      r_old_vld <= 1'b0;
    end else if (key_valid) begin
      r_old_d   <= r_new_d;
      r_old_vld <= r_new_vld;
      r_new_d   <= key_code;
      r_new_vld <= 1'b1;
    end
  end

  // Mux sequencing state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sel     <= DIG_NEW;
      r_dead    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_dead    <= w_dead_nxt;
    end
  end

  // Next-state: wrap the divider, flip the digit and open a one-cycle blank gap.
  always_comb begin
    w_div_last    = (r_div_cnt == DivLast);
    w_div_cnt_nxt = r_div_cnt + DivOne;
    w_sel_nxt     = r_sel;
    w_dead_nxt    = 1'b0;
    if (w_div_last) begin
      w_div_cnt_nxt = '0;
      w_dead_nxt    = 1'b1;
      if (r_sel == DIG_NEW) begin
        w_sel_nxt = DIG_OLD;
      end else begin
        w_sel_nxt = DIG_NEW;
      end
    end
  end

  // Pick the history slot addressed by the current selection.
  always_comb begin
    w_digit     = r_new_d;
    w_digit_vld = r_new_vld;
    if (r_sel == DIG_OLD) begin
      w_digit     = r_old_d;
      w_digit_vld = r_old_vld;
    end
  end

  hex_to_sevenseg u_hex_to_sevenseg (
    .i_hex (w_digit),
    .o_seg (w_enc)
  );

  // Output decode (active-high): blank during the gap, and for slots never written.
  always_comb begin
    w_seg_act = SEG_BLANK;
    w_an_act  = 2'b00;
    if (!r_dead) begin
      if (r_sel == DIG_NEW) begin
        w_an_act = 2'b01;
      end else begin
        w_an_act = 2'b10;
      end
      if (w_digit_vld) begin
        w_seg_act = w_enc;
      end
    end
  end

  // Registered pin drivers so the display pins never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg   <= SEG_BLANK ^ SegMask;
      r_anode <= AnMask;
    end else begin
      r_seg   <= w_seg_act ^ SegMask;
      r_anode <= w_an_act ^ AnMask;
    end
  end

  assign seg       = r_seg;
  assign anode     = r_anode;
  assign digit_new = r_new_d;
  assign digit_old = r_old_d;

endmodule

// File: tb/tb_key_display_mux.sv
// Directed self-checking bench for key_display_mux (MUX_DIV=4).
module tb_key_display_mux;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;

  logic [6:0] seg;
  logic [1:0] anode;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic [6:0] seg_h;
  logic [1:0] anode_h;
  logic [3:0] digit_new_h;
  logic [3:0] digit_old_h;

  int n_checks;
  int n_fail;

  // Active-low pins
  key_display_mux #(
    .MUX_DIV        (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .seg       (seg),
    .anode     (anode),
    .digit_new (digit_new),
    .digit_old (digit_old)
  );

  // Active-high pins, same stimulus
  key_display_mux #(
    .MUX_DIV        (4),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .seg       (seg_h),
    .anode     (anode_h),
    .digit_new (digit_new_h),
    .digit_old (digit_old_h)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_an [16];
    exp_an = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01,
               2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    do_reset();
    n_checks++;
    if (anode !== 2'b11) begin
      n_fail++; $display("FAIL reset_anode: got %b want 11", anode);
    end
    n_checks++;
    if (seg !== 7'h7F) begin
      n_fail++; $display("FAIL reset_seg: got %h want 7f", seg);
    end
    n_checks++;
    if (digit_new !== 4'h0 || digit_old !== 4'h0) begin
      n_fail++; $display("FAIL reset_digits: got %h/%h want 0/0", digit_new, digit_old);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      n_checks++;
      if (anode !== exp_an[k]) begin
        n_fail++; $display("FAIL idle_anode[%0d]: got %b want %b", k, anode, exp_an[k]);
      end
      n_checks++;
      if (seg !== 7'h7F) begin
        n_fail++; $display("FAIL idle_seg[%0d]: got %h want 7f", k, seg);
      end
      n_checks++;
      if (anode === 2'b00) begin
        n_fail++; $display("FAIL idle_both_on[%0d]: got %b want not 00", k, anode);
      end
    end
  endtask

  task automatic test_single_key();
    do_reset();
    key_valid = 1'b1; key_code = 4'h3;
    step();                                  // E1
    key_valid = 1'b0;
    n_checks++;
    if (digit_new !== 4'h3 || digit_old !== 4'h0) begin
      n_fail++; $display("FAIL key3_digits: got %h/%h want 3/0", digit_new, digit_old);
    end
    step();                                  // E2: right window
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h30) begin
      n_fail++; $display("FAIL key3_right: got %b/%h want 10/30", anode, seg);
    end
    step(); step(); step();                  // E5: dead gap
    n_checks++;
    if (anode !== 2'b11 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL key3_dead: got %b/%h want 11/7f", anode, seg);
    end
    step();                                  // E6: left window, old blank
    n_checks++;
    if (anode !== 2'b01 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL key3_left: got %b/%h want 01/7f", anode, seg);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    key_valid = 1'b1; key_code = 4'hA;
    step();                                  // E1
    key_code = 4'h7;
    step();                                  // E2
    key_valid = 1'b0;
    n_checks++;
    if (digit_new !== 4'h7 || digit_old !== 4'hA) begin
      n_fail++; $display("FAIL b2b_digits: got %h/%h want 7/a", digit_new, digit_old);
    end
    step();                                  // E3
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h78) begin
      n_fail++; $display("FAIL b2b_right: got %b/%h want 10/78", anode, seg);
    end
    step(); step(); step();                  // E6
    n_checks++;
    if (anode !== 2'b01 || seg !== 7'h08) begin
      n_fail++; $display("FAIL b2b_left: got %b/%h want 01/08", anode, seg);
    end
  endtask

  task automatic test_wrap_coincident();
    do_reset();
    step(); step(); step();                  // E1..E3, divider now at 3
    key_valid = 1'b1; key_code = 4'h9;
    step();                                  // E4: strobe and wrap together
    key_valid = 1'b0;
    n_checks++;
    if (digit_new !== 4'h9 || digit_old !== 4'h0) begin
      n_fail++; $display("FAIL wrap_digits: got %h/%h want 9/0", digit_new, digit_old);
    end
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL wrap_edge_out: got %b/%h want 10/7f", anode, seg);
    end
    step();                                  // E5: dead
    n_checks++;
    if (anode !== 2'b11 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL wrap_dead: got %b/%h want 11/7f", anode, seg);
    end
    step();                                  // E6: left, old blank
    n_checks++;
    if (anode !== 2'b01 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL wrap_left: got %b/%h want 01/7f", anode, seg);
    end
    step(); step(); step(); step();          // E10: right shows 9
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h10) begin
      n_fail++; $display("FAIL wrap_right: got %b/%h want 10/10", anode, seg);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_valid = 1'b1; key_code = 4'h5;
    step();                                  // E1
    step();                                  // E2: repeated 5
    key_valid = 1'b0;
    n_checks++;
    if (digit_new !== 4'h5 || digit_old !== 4'h5) begin
      n_fail++; $display("FAIL repeat_digits: got %h/%h want 5/5", digit_new, digit_old);
    end
    step();                                  // E3
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h12) begin
      n_fail++; $display("FAIL repeat_right: got %b/%h want 10/12", anode, seg);
    end
    rst_n = 1'b0;
    step();                                  // E4: reset
    rst_n = 1'b1;
    n_checks++;
    if (digit_new !== 4'h0 || digit_old !== 4'h0 || anode !== 2'b11 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL midreset_state: got %h/%h %b/%h want 0/0 11/7f",
                         digit_new, digit_old, anode, seg);
    end
    step();                                  // E5: right window, blank
    n_checks++;
    if (anode !== 2'b10 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL midreset_right: got %b/%h want 10/7f", anode, seg);
    end
    step(); step(); step();                  // E8
    n_checks++;
    if (anode !== 2'b10) begin
      n_fail++; $display("FAIL midreset_window_end: got %b want 10", anode);
    end
    step();                                  // E9
    n_checks++;
    if (anode !== 2'b11) begin
      n_fail++; $display("FAIL midreset_dead: got %b want 11", anode);
    end
    step();                                  // E10
    n_checks++;
    if (anode !== 2'b01 || seg !== 7'h7F) begin
      n_fail++; $display("FAIL midreset_left: got %b/%h want 01/7f", anode, seg);
    end
  endtask

  task automatic test_polarity();
    do_reset();
    n_checks++;
    if (anode_h !== 2'b00 || seg_h !== 7'h00) begin
      n_fail++; $display("FAIL pol_reset: got %b/%h want 00/00", anode_h, seg_h);
    end
    key_valid = 1'b1; key_code = 4'hF;
    step();                                  // E1
    key_valid = 1'b0;
    n_checks++;
    if (digit_new_h !== 4'hF || digit_old_h !== 4'h0) begin
      n_fail++; $display("FAIL pol_digits: got %h/%h want f/0", digit_new_h, digit_old_h);
    end
    step();                                  // E2
    n_checks++;
    if (anode_h !== 2'b01 || seg_h !== 7'h71) begin
      n_fail++; $display("FAIL pol_right: got %b/%h want 01/71", anode_h, seg_h);
    end
    step(); step(); step();                  // E5
    n_checks++;
    if (anode_h !== 2'b00 || seg_h !== 7'h00) begin
      n_fail++; $display("FAIL pol_dead: got %b/%h want 00/00", anode_h, seg_h);
    end
    step();                                  // E6
    n_checks++;
    if (anode_h !== 2'b10 || seg_h !== 7'h00) begin
      n_fail++; $display("FAIL pol_left: got %b/%h want 10/00", anode_h, seg_h);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    test_reset();
    test_single_key();
    test_back_to_back();
    test_wrap_coincident();
    test_reset_mid();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
